wb_count_capture: RTL and testbench
===================================

WB_COUNT_CAPTURE -- requirements
Module: wb_count_capture

Interface
REQ-001 Parameter BITS, default 32: width of the captured count and of the Wishbone data path.
REQ-002 Parameter DEPTH, default 8: timestamp FIFO depth, power of two, 2..16.
REQ-003 Clocking and reset are fixed: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; same clock as the upstream counter.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 count  input  BITS  live value of the upstream counter.
REQ-007 trig_in  input  1  asynchronous external event pin, taken from io_in.
REQ-008 valid  input  1  Wishbone request (cyc & stb).
REQ-009 wstrb  input  4  byte write strobes (sel & we); all zero means read.
REQ-010 addr  input  2  word address, taken from wbs_adr_i[3:2].
REQ-011 wdata  input  BITS  write data.
REQ-012 rdata  output  BITS  read data, registered.
REQ-013 ready  output  1  Wishbone ack, one-cycle pulse.
REQ-014 irq  output  1  level interrupt: FIFO not empty AND irq_en.

Function
REQ-015 trig_in passes through a 2-flop synchronizer plus an edge register; a rising edge is detected when sync2=1 and edge_reg=0.
REQ-016 trig_in first sampled high at edge k: FIFO write occurs at edge k+2 and stores the value of count present at that edge.
REQ-017 A capture occurs only when CTRL.enable=1; edges while disabled are discarded, not queued.
REQ-018 Register map: addr 0 DATA (read pops the FIFO head); addr 1 STATUS = {overflow[8], level[7:3] (0..DEPTH), full[1], empty[0]}; addr 2 CTRL = {irq_en[2], clear[1], enable[0]}; addr 3 reads 0.
REQ-019 Handshake: with valid=1 and ready=0 at an edge, the access is performed and ready=1 with rdata valid during the next cycle; ready is then 0 for at least one cycle; no back-to-back acks.
REQ-020 CTRL writes update only the bytes whose wstrb bit is set; writes to DATA, STATUS or addr 3 are ignored but still acknowledged.
REQ-021 CTRL.clear is self-clearing: writing 1 flushes the FIFO (level=0), clears overflow, and reads back 0.
REQ-022 DATA read when empty returns 0 and leaves the pointers unchanged.
REQ-023 A capture while full is dropped, the FIFO contents are unchanged, and overflow is set sticky.
REQ-024 A capture and a pop in the same cycle both take effect: level is unchanged, including when full; no overflow when full.
REQ-025 A clear and a capture in the same cycle: the clear wins and the FIFO is empty afterwards.
REQ-026 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; level is held in a separate log2(DEPTH)+1-bit counter.
REQ-027 rdata holds its last value while ready=0.

Reset
REQ-028 On reset: rdata=0, ready=0, irq=0, enable=0, irq_en=0, overflow=0, level=0, pointers=0, and all synchronizer/edge flops=0.
REQ-029 Reset during a pending access cancels it; no ack is issued for that access.
REQ-030 FIFO storage is not reset; it is unobservable because empty gates every read.

Structure
REQ-031 A shared package holds the address constants (ADDR_DATA=0, ADDR_STATUS=1, ADDR_CTRL=2), the CTRL and STATUS bit positions, and the default DEPTH.
REQ-032 One sub-module, capture_fifo (synchronous, parameterized width/depth, push/pop/flush, full/empty/level), is instantiated once.
REQ-033 The top level holds the synchronizer, the edge detector, the register file and the Wishbone handshake.

Verification
REQ-034 Scenario: write CTRL=1, count=0x100 free-running +1/cycle, trig_in pulse of 3 cycles -> one entry, with value = count at edge k+2; DATA read returns it; STATUS.empty=1 afterwards.
REQ-035 Scenario: DEPTH=8, 10 trigger edges with no reads -> level=8, full=1, overflow=1; 8 DATA reads return the first 8 timestamps in order; a 9th read returns 0.
REQ-036 Scenario: FIFO full, a pop coinciding with a capture edge -> level stays 8, overflow stays 0, and the newest entry is the value at the capture.
REQ-037 Scenario: write CTRL=0x3 in the same cycle as a capture -> level=0, overflow=0, CTRL reads back 0x1.
REQ-038 Scenario: irq_en=1 with one capture -> irq rises in the cycle after the write and falls in the cycle after the pop; with irq_en=0, irq stays 0.
REQ-039 Scenario: assert reset during an outstanding read and during a trigger pulse -> no ack, and every output matches REQ-028.

Source files
------------

// File: rtl/wb_count_capture_pkg.sv
// Shared constants for the Wishbone count-capture block: register map, CTRL/STATUS
// bit positions, default FIFO depth and the STATUS word packer.
package wb_count_capture_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STATUS_EMPTY_BIT    = 0;
    localparam int STATUS_FULL_BIT     = 1;
    localparam int STATUS_LEVEL_LSB    = 3;
    localparam int STATUS_LEVEL_MSB    = 7;
    localparam int STATUS_OVERFLOW_BIT = 8;
    localparam int STATUS_W            = 9;

    localparam int DEFAULT_DEPTH = 8;

    function automatic logic [STATUS_W-1:0] pack_status(
        input logic       overflow,
        input logic [4:0] level,
        input logic       full,
        input logic       empty
    );
        logic [STATUS_W-1:0] word;
        word = {STATUS_W{1'b0}};
        word[STATUS_OVERFLOW_BIT]                  = overflow;
        word[STATUS_LEVEL_MSB:STATUS_LEVEL_LSB]    = level;
        word[STATUS_FULL_BIT]                      = full;
        word[STATUS_EMPTY_BIT]                     = empty;
        return word;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous timestamp FIFO with push/pop/flush and a separate level counter.
// Storage is left unreset on purpose; the empty flag gates every observable read.
module capture_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (level_r == LW'(1'b0));
    assign full  = (level_r == LW'(DEPTH));
    assign level = level_r;
    assign head  = mem_r[rd_ptr_r];

    // A push into a full FIFO is accepted only when a pop frees the slot that same cycle
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
    end

    // Pointers and level; flush has priority over any concurrent push or pop
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (do_push_s && !do_pop_s) begin
                level_r <= level_r + LW'(1'b1);
            end else if (do_pop_s && !do_push_s) begin
                level_r <= level_r - LW'(1'b1);
            end else begin
                level_r <= level_r;
            end
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (do_push_s && !flush && !reset) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/wb_count_capture.sv
// Wishbone-attached timestamp capture: a synchronized external trigger records the
// live counter value into a FIFO that software drains through a small register file.
module wb_count_capture
    import wb_count_capture_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] count,
    input  logic            trig_in,
    input  logic            valid,
    input  logic [3:0]      wstrb,
    input  logic [1:0]      addr,
    input  logic [BITS-1:0] wdata,
    output logic [BITS-1:0] rdata,
    output logic            ready,
    output logic            irq
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic            sync1_r;
    logic            sync2_r;
    logic            edge_r;
    logic            enable_r;
    logic            irq_en_r;
    logic            overflow_r;
    logic            ready_r;
    logic            irq_r;
    logic [BITS-1:0] rdata_r;

    logic            access_s;
    logic            is_read_s;
    logic            ctrl_wr_s;
    logic            flush_s;
    logic            pop_s;
    logic            rise_s;
    logic            push_s;
    logic            push_ok_s;
    logic            irq_en_next_s;
    logic            nonempty_next_s;
    logic [8:0]      status_s;
    logic [BITS-1:0] read_word_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [LW-1:0]   fifo_level_s;
    logic [BITS-1:0] fifo_head_s;
    logic            unused_bits_s;

    assign unused_bits_s = ^{wdata[BITS-1:3], wstrb[3:1]};

    assign rdata = rdata_r;
    assign ready = ready_r;
    assign irq   = irq_r;

    // Request decode, read-data mux and the next interrupt level
    always_comb begin
        access_s  = valid & ~ready_r;
        is_read_s = (wstrb == 4'b0000);
        ctrl_wr_s = access_s & ~is_read_s & (addr == ADDR_CTRL) & wstrb[0];
        flush_s   = ctrl_wr_s & wdata[CTRL_CLEAR_BIT];
        pop_s     = access_s & is_read_s & (addr == ADDR_DATA) & ~fifo_empty_s;
        rise_s    = sync2_r & ~edge_r;
        push_s    = rise_s & enable_r;
        push_ok_s = push_s & (~fifo_full_s | pop_s);
        status_s  = pack_status(overflow_r, 5'(fifo_level_s), fifo_full_s, fifo_empty_s);

        read_word_s = {BITS{1'b0}};
        case (addr)
            ADDR_DATA:   read_word_s = fifo_empty_s ? {BITS{1'b0}} : fifo_head_s;
            ADDR_STATUS: read_word_s = BITS'(status_s);
            ADDR_CTRL:   read_word_s = BITS'({irq_en_r, 1'b0, enable_r});
            default:     read_word_s = {BITS{1'b0}};
        endcase

        if (ctrl_wr_s) begin
            irq_en_next_s = wdata[CTRL_IRQ_EN_BIT];
        end else begin
            irq_en_next_s = irq_en_r;
        end

        // irq is registered, so it is computed from the FIFO occupancy after this edge
        if (flush_s) begin
            nonempty_next_s = 1'b0;
        end else if (fifo_empty_s) begin
            nonempty_next_s = push_ok_s;
        end else if ((fifo_level_s == LW'(1'b1)) && pop_s && !push_ok_s) begin
            nonempty_next_s = 1'b0;
        end else begin
            nonempty_next_s = 1'b1;
        end
    end

    // Trigger synchronizer and edge register
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            edge_r  <= 1'b0;
        end else begin
            sync1_r <= trig_in;
            sync2_r <= sync1_r;
            edge_r  <= sync2_r;
        end
    end

    // Control bits, sticky overflow and the interrupt output
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_r   <= 1'b0;
            irq_en_r   <= 1'b0;
            overflow_r <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                enable_r <= wdata[CTRL_ENABLE_BIT];
                irq_en_r <= wdata[CTRL_IRQ_EN_BIT];
            end else begin
                enable_r <= enable_r;
                irq_en_r <= irq_en_r;
            end
            if (flush_s) begin
                overflow_r <= 1'b0;
            end else if (push_s && fifo_full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
            irq_r <= irq_en_next_s & nonempty_next_s;
        end
    end

    // Wishbone handshake: one-cycle ack, then forced idle so acks never run back to back
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r <= 1'b0;
            rdata_r <= {BITS{1'b0}};
        end else if (access_s) begin
            ready_r <= 1'b1;
            rdata_r <= read_word_s;
        end else begin
            ready_r <= 1'b0;
            rdata_r <= rdata_r;
        end
    end

    capture_fifo #(
        .WIDTH (BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .wdata (count),
        .head  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

endmodule

// File: tb/tb_wb_count_capture.sv
// Self-checking bench for wb_count_capture: directed scenarios plus randomized
// trigger/read traffic compared against a queue-based reference model.
module tb_wb_count_capture;
    import wb_count_capture_pkg::*;

    localparam int BITS  = 32;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] count;
    logic        trig_in;
    logic        valid;
    logic [3:0]  wstrb;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    bit          m_overflow;
    bit          m_enable;
    bit          m_irq_en;

    wb_count_capture #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .count(count), .trig_in(trig_in),
        .valid(valid), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .irq(irq)
    );

    always #5 clk = ~clk;

    // Free-running upstream counter, +1 per cycle, stable around every rising edge
    initial begin
        count = 32'h100;
        forever begin
            @(negedge clk);
            count = count + 32'd1;
        end
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        exp_q.delete();
        m_overflow = 1'b0;
        m_enable   = 1'b0;
        m_irq_en   = 1'b0;
    endfunction

    function automatic void model_capture(input logic [31:0] v);
        if (m_enable) begin
            if (exp_q.size() == DEPTH) m_overflow = 1'b1;
            else exp_q.push_back(v);
        end
    endfunction

    function automatic logic [31:0] model_pop();
        if (exp_q.size() == 0) return 32'd0;
        return exp_q.pop_front();
    endfunction

    function automatic void model_write(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
        if (a == ADDR_CTRL && s[0]) begin
            m_enable = d[0];
            m_irq_en = d[2];
            if (d[1]) begin
                exp_q.delete();
                m_overflow = 1'b0;
            end
        end
    endfunction

    function automatic logic [31:0] model_status();
        int n;
        n = exp_q.size();
        return (32'(m_overflow) << 8) | (32'(n) << 3) | (32'(n == DEPTH) << 1) | 32'(n == 0);
    endfunction

    function automatic logic [31:0] model_ctrl();
        return {29'd0, m_irq_en, 1'b0, m_enable};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wb_access(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                             output logic [31:0] rd);
        int n;
        @(negedge clk);
        valid = 1'b1; addr = a; wstrb = s; wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((ready !== 1'b1) && (n < 4));
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ack_timeout: addr=%0d ready=%b expected 1", a, ready);
        end
        rd = rdata;
        valid = 1'b0; wstrb = 4'b0000;
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] rd;
        wb_access(a, s, d, rd);
        model_write(a, s, d);
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] rd);
        wb_access(a, 4'b0000, 32'd0, rd);
    endtask

    // Pulse the trigger; the capture is the count present two edges after first sampling
    task automatic pulse(input int len);
        logic [31:0] cap;
        @(negedge clk);
        trig_in = 1'b1;
        @(posedge clk);
        cap = count + 32'd2;
        for (int i = 1; i < len; i++) @(negedge clk);
        @(negedge clk);
        trig_in = 1'b0;
        repeat (3) @(negedge clk);
        model_capture(cap);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b1; valid = 1'b0; trig_in = 1'b0; wstrb = 4'b0000; addr = 2'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        reset = 1'b0;
        model_reset();
        wb_read(ADDR_STATUS, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL reset_status: got %h expected 1", rd); end
        wb_read(ADDR_CTRL, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", rd); end
        wb_read(ADDR_DATA, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_data_empty: got %h expected 0", rd); end
        wb_read(ADDR_RSVD, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rsvd_read: got %h expected 0", rd); end
    endtask

    task automatic test_single_capture();
        logic [31:0] rd, ex;
        wb_write(ADDR_CTRL, 4'hF, 32'h1);
        pulse(3);
        wb_read(ADDR_STATUS, rd);
        checks++; if (rd !== 32'h8) begin errors++; $display("FAIL single_status: got %h expected 8", rd); end
        wb_read(ADDR_DATA, rd);
        ex = model_pop();
        checks++; if (rd !== ex) begin errors++; $display("FAIL single_data: got %h expected %h", rd, ex); end
        wb_read(ADDR_STATUS, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL single_empty: got %h expected 1", rd); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd, ex;
        for (int i = 0; i < 10; i++) pulse(1 + (i % 3));
        wb_read(ADDR_STATUS, rd);
        checks++; if (rd !== 32'h142) begin errors++; $display("FAIL ovf_status: got %h expected 142", rd); end
        for (int i = 0; i < 9; i++) begin
            wb_read(ADDR_DATA, rd);
            ex = model_pop();
            checks++; if (rd !== ex) begin errors++; $display("FAIL ovf_read%0d: got %h expected %h", i, rd, ex); end
        end
        wb_read(ADDR_STATUS, rd);
        checks++; if (rd !== 32'h101) begin errors++; $display("FAIL ovf_sticky: got %h expected 101", rd); end
    endtask

    task automatic test_pop_capture();
        logic [31:0] rd, ex, cap;
        wb_write(ADDR_CTRL, 4'h1, 32'h3);
        for (int i = 0; i < DEPTH; i++) pulse(2);
        wb_read(ADDR_STATUS, rd);
        checks++; if (rd !== 32'h42) begin errors++; $display("FAIL popcap_full: got %h expected 42", rd); end
        @(negedge clk);
        trig_in = 1'b1;
        @(posedge clk);
        cap = count + 32'd2;
        @(negedge clk);
        @(negedge clk);
        valid = 1'b1; addr = ADDR_DATA; wstrb = 4'b0000;
        @(negedge clk);
        trig_in = 1'b0;
        ex = model_pop();
        model_capture(cap);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL popcap_ack: got %b expected 1", ready); end
        checks++; if (rdata !== ex) begin errors++; $display("FAIL popcap_data: got %h expected %h", rdata, ex); end
        valid = 1'b0;
        repeat (3) @(negedge clk);
        wb_read(ADDR_STATUS, rd);
        checks++; if (rd !== 32'h42) begin errors++; $display("FAIL popcap_level: got %h expected 42", rd); end
        for (int i = 0; i < DEPTH; i++) begin
            wb_read(ADDR_DATA, rd);
            ex = model_pop();
            checks++; if (rd !== ex) begin errors++; $display("FAIL popcap_drain%0d: got %h expected %h", i, rd, ex); end
        end
    endtask

    task automatic test_clear_capture();
        logic [31:0] rd;
        for (int i = 0; i < DEPTH + 1; i++) pulse(1);
        @(negedge clk);
        trig_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        valid = 1'b1; addr = ADDR_CTRL; wstrb = 4'h1; wdata = 32'h3;
        @(negedge clk);
        trig_in = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL clrcap_ack: got %b expected 1", ready); end
        valid = 1'b0; wstrb = 4'b0000;
        model_write(ADDR_CTRL, 4'h1, 32'h3);
        repeat (3) @(negedge clk);
        wb_read(ADDR_STATUS, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL clrcap_status: got %h expected 1", rd); end
        wb_read(ADDR_CTRL, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL clrcap_ctrl: got %h expected 1", rd); end
    endtask

    task automatic test_write_mask();
        logic [31:0] rd, ex;
        wb_write(ADDR_CTRL, 4'b1110, 32'hFFFF_FFF8);
        wb_write(ADDR_STATUS, 4'hF, 32'hFFFF_FFFF);
        wb_write(ADDR_RSVD, 4'hF, 32'h1234_5678);
        wb_write(ADDR_DATA, 4'hF, 32'hDEAD_BEEF);
        wb_read(ADDR_CTRL, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL mask_ctrl: got %h expected 1", rd); end
        wb_read(ADDR_STATUS, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL mask_status: got %h expected 1", rd); end
        pulse(1);
        wb_read(ADDR_DATA, rd);
        ex = model_pop();
        checks++; if (rd !== ex) begin errors++; $display("FAIL mask_capture: got %h expected %h", rd, ex); end
    endtask

    task automatic test_irq();
        logic [31:0] rd, ex, cap;
        wb_write(ADDR_CTRL, 4'h1, 32'h5);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b expected 0", irq); end
        @(negedge clk);
        trig_in = 1'b1;
        @(posedge clk);
        cap = count + 32'd2;
        @(negedge clk);
        trig_in = 1'b0;
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq); end
        @(negedge clk);
        model_capture(cap);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", irq); end
        valid = 1'b1; addr = ADDR_DATA; wstrb = 4'b0000;
        @(negedge clk);
        ex = model_pop();
        checks++; if (rdata !== ex) begin errors++; $display("FAIL irq_data: got %h expected %h", rdata, ex); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b expected 0", irq); end
        valid = 1'b0;
        wb_write(ADDR_CTRL, 4'h1, 32'h1);
        pulse(2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked%0d: got %b expected 0", i, irq); end
        end
        wb_read(ADDR_DATA, rd);
        ex = model_pop();
        checks++; if (rd !== ex) begin errors++; $display("FAIL irq_masked_data: got %h expected %h", rd, ex); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ex;
        ex = model_status();
        @(negedge clk);
        valid = 1'b1; addr = ADDR_STATUS; wstrb = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (ready !== ((i % 2) == 0)) begin
                errors++; $display("FAIL b2b_ready%0d: got %b expected %b", i, ready, (i % 2) == 0);
            end
            checks++; if (rdata !== ex) begin errors++; $display("FAIL b2b_rdata%0d: got %h expected %h", i, rdata, ex); end
        end
        valid = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] rd, ex, d;
        logic        irq_ex;
        for (int r = 0; r < 8; r++) begin
            d = $urandom;
            d[0] = ($urandom_range(0, 3) != 0);
            d[1] = ($urandom_range(0, 3) == 0);
            wb_write(ADDR_CTRL, 4'($urandom_range(1, 15)), d);
            if ($urandom_range(0, 1) == 1) wb_write(($urandom_range(0, 1) == 1) ? ADDR_STATUS : ADDR_RSVD, 4'hF, $urandom);
            for (int p = 0, n = $urandom_range(0, 11); p < n; p++) pulse($urandom_range(1, 4));
            wb_read(ADDR_STATUS, rd);
            ex = model_status();
            checks++; if (rd !== ex) begin errors++; $display("FAIL rnd_status%0d: got %h expected %h", r, rd, ex); end
            irq_ex = m_irq_en && (exp_q.size() != 0);
            checks++; if (irq !== irq_ex) begin errors++; $display("FAIL rnd_irq%0d: got %b expected %b", r, irq, irq_ex); end
            for (int k = 0, n = $urandom_range(0, 10); k < n; k++) begin
                wb_read(ADDR_DATA, rd);
                ex = model_pop();
                checks++; if (rd !== ex) begin errors++; $display("FAIL rnd_data%0d_%0d: got %h expected %h", r, k, rd, ex); end
            end
            wb_read(ADDR_CTRL, rd);
            ex = model_ctrl();
            checks++; if (rd !== ex) begin errors++; $display("FAIL rnd_ctrl%0d: got %h expected %h", r, rd, ex); end
        end
    endtask

    task automatic test_reset_pending();
        logic [31:0] rd;
        wb_write(ADDR_CTRL, 4'h1, 32'h5);
        pulse(2);
        wb_read(ADDR_STATUS, rd);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rstp_pre_irq: got %b expected 1", irq); end
        @(negedge clk);
        valid = 1'b1; addr = ADDR_DATA; wstrb = 4'b0000; trig_in = 1'b1; reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstp_ready%0d: got %b expected 0", i, ready); end
            checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rstp_rdata%0d: got %h expected 0", i, rdata); end
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstp_irq%0d: got %b expected 0", i, irq); end
        end
        reset = 1'b0; valid = 1'b0; trig_in = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstp_post_ready: got %b expected 0", ready); end
        wb_read(ADDR_STATUS, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL rstp_status: got %h expected 1", rd); end
        wb_read(ADDR_CTRL, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstp_ctrl: got %h expected 0", rd); end
        pulse(2);
        wb_read(ADDR_STATUS, rd);
        checks++; if (rd !== model_status()) begin errors++; $display("FAIL disabled_capture: got %h expected %h", rd, model_status()); end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_overflow();
        test_pop_capture();
        test_clear_capture();
        test_write_mask();
        test_irq();
        test_back_to_back();
        test_random();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
